register_file: RTL and testbench

//   32-entry x 32-bit general-purpose register file for the single-cycle CPU datapath.
//   Two combinational read ports feed the ALU operands (rs/rt).
//   One clocked write port takes the writeback result.
//   A third combinational debug port (regNo/val) exposes any register for inspection.

---
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32 x 32-bit general-purpose register file for the single-cycle CPU
//   datapath. There are two combinational operand read ports (Read1/Data1 and
//   Read2/Data2), one clocked write port (WriteReg/WriteData/RegWrite) and a
//   combinational debug read port (regNo/val). Register 0 is hardwired to zero.
//
// Ports
//   clk        in   1       system clock; register updates on the rising edge
//   rst_n      in   1       asynchronous active-low reset; clears all registers
//   Read1      in   ADDR_W  index of the register driven on Data1
//   Read2      in   ADDR_W  index of the register driven on Data2
//   WriteReg   in   ADDR_W  index of the register to write
//   WriteData  in   DATA_W  value to write
//   RegWrite   in   1       write enable, active high
//   Data1      out  DATA_W  contents of register Read1
//   Data2      out  DATA_W  contents of register Read2
//   regNo      in   ADDR_W  debug index
//   val        out  DATA_W  contents of register regNo
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  input  logic [ADDR_W-1:0] regNo,
  output logic [DATA_W-1:0] val
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Storage is flop based: every register must clear asynchronously, which
  // rules out a RAM macro.
  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] write_en;

  // One-hot write decode. Entry 0 never asserts, so x0 is never written.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_write_dec
    if (gi == 0) begin : g_zero
      assign write_en[gi] = 1'b0;
    end else begin : g_reg
      assign write_en[gi] = RegWrite && (WriteReg == ADDR_W'(gi));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (write_en[i]) begin
          regs_reg[i] <= WriteData;
        end
      end
    end
  end

  // Combinational reads with no write bypass: a same-cycle write is visible
  // only after the edge. Index 0 is forced to zero explicitly so that x0 reads
  // as zero regardless of what the storage array holds.
  always_comb begin
    Data1 = (Read1 == '0) ? '0 : regs_reg[Read1];
    Data2 = (Read2 == '0) ? '0 : regs_reg[Read2];
    val   = (regNo == '0) ? '0 : regs_reg[regNo];
  end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file. Inputs change on the
//   falling clock edge; outputs are sampled away from the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic [4:0]  regNo;
  logic [31:0] val;

  int checks;
  int failures;
  logic [31:0] exp_regs [32];

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Data1     (Data1),
    .Data2     (Data2),
    .regNo     (regNo),
    .val       (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write on the falling edge, let one rising edge pass, and return
  // on the following falling edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic en);
    WriteReg  = addr;
    WriteData = data;
    RegWrite  = en;
    @(posedge clk);
    @(negedge clk);
    RegWrite  = 1'b0;
    $display("write en=%0b reg=%0d data=%h", en, addr, data);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    Read1     = '0;
    Read2     = '0;
    regNo     = '0;
    WriteReg  = '0;
    WriteData = '0;
    RegWrite  = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load a value so the asynchronous clear has something to remove.
    do_write(5'd5, 32'h0000_0077, 1'b1);
    Read1 = 5'd5; Read2 = 5'd5; regNo = 5'd5;
    #1;
    check("pre_reset_data1", Data1, 32'h0000_0077);

    // Reset asserted mid-cycle, well before the next rising edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_clear_data1", Data1, 32'h0);
    check("async_clear_data2", Data2, 32'h0);
    check("async_clear_val",   val,   32'h0);
    $display("reset asserted mid-cycle at t=%0t", $time);

    // A write attempted while in reset must be ignored across a rising edge.
    WriteReg = 5'd5; WriteData = 32'hFFFF_FFFF; RegWrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Read1 = 5'(i); Read2 = 5'(31 - i); regNo = 5'(i);
      #1;
      check($sformatf("reset_data1_r%0d", i), Data1, 32'h0);
      check($sformatf("reset_data2_r%0d", 31 - i), Data2, 32'h0);
      check($sformatf("reset_val_r%0d", i), val, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // Write then read.
    do_write(5'd1, 32'hAAAA_AAAA, 1'b1);
    Read1 = 5'd1; regNo = 5'd1;
    #1;
    check("wr1_data1", Data1, 32'hAAAA_AAAA);
    check("wr1_val",   val,   32'hAAAA_AAAA);

    // Second write.
    do_write(5'd2, 32'h5555_5555, 1'b1);
    Read2 = 5'd2;
    #1;
    check("wr2_data2", Data2, 32'h5555_5555);
    check("wr2_data1", Data1, 32'hAAAA_AAAA);

    // x0 protection.
    do_write(5'd0, 32'hFFFF_FFFF, 1'b1);
    Read1 = 5'd0; regNo = 5'd0;
    #1;
    check("x0_data1", Data1, 32'h0);
    check("x0_val",   val,   32'h0);

    // Write disable held over several edges.
    WriteReg = 5'd1; WriteData = 32'h1234_5678; RegWrite = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    Read1 = 5'd1;
    #1;
    check("wdis_data1", Data1, 32'hAAAA_AAAA);
    $display("write disabled for 3 edges");

    // No bypass: old value before the edge, new value after it.
    Read1 = 5'd3; WriteReg = 5'd3; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
    #1;
    check("nobypass_before", Data1, 32'h0);
    @(posedge clk);
    #1;
    check("nobypass_after", Data1, 32'hDEAD_BEEF);
    @(negedge clk);
    RegWrite = 1'b0;
    $display("no-bypass write reg=3 data=deadbeef");

    // Back-to-back writes to one register: the last edge wins.
    WriteReg = 5'd4; WriteData = 32'h0000_0001; RegWrite = 1'b1;
    @(posedge clk);
    #1 WriteData = 32'h0000_0002;
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    regNo = 5'd4;
    #1;
    check("b2b_val", val, 32'h0000_0002);
    $display("back-to-back write reg=4");

    // Fill every register with a distinct pattern and read all of them back.
    exp_regs[0] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i != 0) exp_regs[i] = 32'hA500_0000 | (32'(i) * 32'h0001_0101);
      do_write(5'(i), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      Read1 = 5'(i); Read2 = 5'(31 - i); regNo = 5'(i);
      #1;
      check($sformatf("fill_data1_r%0d", i), Data1, exp_regs[i]);
      check($sformatf("fill_data2_r%0d", 31 - i), Data2, exp_regs[31 - i]);
      check($sformatf("fill_val_r%0d", i), val, exp_regs[i]);
    end
    $display("fill and readback of 32 registers done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
